inst_fetch_sched: RTL and testbench

- Fetch controller and port arbiter for the single-read-port, combinational instruction ROM (256 words, byte address bits [9:2]).
- Owns the PC and issues one ROM read per cycle into a small fetch queue with a valid/ready interface to decode.
- Handles branch/jump redirects and out-of-range faults.
- Shares the ROM port with a debug/loader read requester.

---
 rtl/inst_fetch_sched.sv | 127 ++++++++++++
 tb/tb_inst_fetch_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_sched.sv
// Instruction fetch controller: owns the PC, fills a small fetch queue from the
// single-port combinational ROM, and lends the ROM port to a debug reader with
// a bounded starvation limit for fetch.
module inst_fetch_sched #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          QDEPTH       = 2,
  parameter int          ROM_WORDS    = 256,
  parameter int          STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rdata
);

  localparam int          PW       = (QDEPTH > 2) ? 2 : 1;
  localparam int          CW       = $clog2(QDEPTH + 1);
  localparam int          SW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] PC_LIMIT = 32'(ROM_WORDS * 4);
  localparam logic [CW-1:0] QFULL  = CW'(QDEPTH);
  localparam logic [SW-1:0] SMAX   = SW'(STARVE_LIMIT);

  logic [31:0]   pc;
  logic [SW-1:0] starve;
  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];

  logic pop, fetch_want, debug_win, fetch_win, pc_bad, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Arbitration between decode-driven fetch and the debug reader.
  always_comb begin
    out_valid  = (count != '0);
    pop        = out_valid & out_ready;
    fetch_want = ~fault & ~redirect_valid & ((count < QFULL) | pop);
    debug_win  = dbg_req & ~(fetch_want & (starve == SMAX));
    fetch_win  = fetch_want & ~debug_win;
    pc_bad     = (pc[1:0] != 2'b00) | (pc >= PC_LIMIT);
    push       = fetch_win & ~pc_bad;
    imem_addr  = debug_win ? dbg_addr : pc;
    out_pc     = out_valid ? q_pc[head]   : '0;
    out_inst   = out_valid ? q_inst[head] : '0;
  end

  // PC, fault capture and fetch starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
      starve   <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      fault  <= 1'b0;
      starve <= '0;
    end else begin
      if (fetch_win && pc_bad) begin
        fault    <= 1'b1;
        fault_pc <= pc;
      end else if (push) begin
        pc <= pc + 32'd4;
      end
      if (fetch_want && debug_win)
        starve <= (starve == SMAX) ? starve : starve + SW'(1);
      else
        starve <= '0;
    end
  end

  // Queue pointers and occupancy; a redirect kills everything queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect_valid) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (pop)  head <= ptr_inc(head);
      if (push) tail <= ptr_inc(tail);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= pc;
      q_inst[tail] <= imem_inst;
    end
  end

  // Debug read return: data captured in the cycle the port was won.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_gnt   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_gnt <= debug_win;
      if (debug_win) dbg_rdata <= imem_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_sched.sv
module tb_inst_fetch_sched;
  localparam int QDEPTH = 2;
  localparam int LIMIT  = 3;
  localparam int ROMB   = 256 * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;

  int checks = 0;
  int failures = 0;

  inst_fetch_sched dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .fault(fault), .fault_pc(fault_pc), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  assign imem_inst = rom(imem_addr);

  // Reference model state
  logic [31:0] m_pc;
  logic [63:0] mq[$];
  bit          m_fault;
  logic [31:0] m_fpc;
  bit          m_gnt;
  logic [31:0] m_rdata;
  int          m_starve;
  bit          last_dwin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; mq.delete(); m_fault = 0; m_fpc = 0;
    m_gnt = 0; m_rdata = 0; m_starve = 0; last_dwin = 0;
  endtask

  // Called at posedge+1 with inputs set; compares at negedge, advances model.
  task automatic cycle();
    bit valid, pop, want, dwin, fwin, bad;
    logic [63:0] h;
    @(negedge clk);
    valid = (mq.size() != 0);
    chk("out_valid", {31'b0, out_valid}, {31'b0, valid});
    if (valid) begin
      h = mq[0];
      chk("out_pc", out_pc, h[63:32]);
      chk("out_inst", out_inst, h[31:0]);
    end
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
    chk("fault_pc", fault_pc, m_fpc);
    chk("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, m_gnt});
    if (m_gnt) chk("dbg_rdata", dbg_rdata, m_rdata);
    pop  = valid && out_ready;
    want = !m_fault && !redirect_valid && (mq.size() < QDEPTH || pop);
    dwin = dbg_req && !(want && m_starve == LIMIT);
    fwin = want && !dwin;
    chk("imem_addr", imem_addr, dwin ? dbg_addr : m_pc);
    m_gnt = dwin;
    if (dwin) m_rdata = rom(dbg_addr);
    if (redirect_valid) begin
      mq.delete(); m_pc = redirect_pc; m_starve = 0; m_fault = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      bad = (m_pc % 4 != 0) || (m_pc >= ROMB);
      if (fwin) begin
        if (bad) begin m_fault = 1; m_fpc = m_pc; end
        else begin mq.push_back({m_pc, rom(m_pc)}); m_pc = m_pc + 4; end
      end
      m_starve = (want && dwin) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
    end
    last_dwin = dwin;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int gnts;
    int r;
    reset = 1'b0; redirect_valid = 0; redirect_pc = 0; out_ready = 1;
    dbg_req = 0; dbg_addr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    reset = 1'b1;

    // First fetch and streaming
    cycle();
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_pc", out_pc, 32'h0);
    chk("first_inst", out_inst, 32'hA5A5_0000);
    cycle();
    chk("second_pc", out_pc, 32'h4);

    // Back-pressure from reset
    do_reset();
    out_ready = 0;
    repeat (5) cycle();
    chk("stall_pc", out_pc, 32'h0);
    chk("stall_addr", imem_addr, 32'h8);
    out_ready = 1;
    chk("drain0", out_pc, 32'h0); cycle();
    chk("drain4", out_pc, 32'h4); cycle();
    chk("drain8", out_pc, 32'h8);

    // Redirect with queue {8,12}
    redirect_valid = 1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 0;
    chk("redir_flush", {31'b0, out_valid}, 32'd0);
    cycle();
    chk("redir_pc", out_pc, 32'h100);
    chk("redir_inst", out_inst, 32'hA5A5_0100);

    // Misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h102;
    cycle();
    redirect_valid = 0;
    cycle();
    chk("mis_fault", {31'b0, fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h102);
    repeat (3) cycle();
    chk("mis_nopush", {31'b0, out_valid}, 32'd0);
    redirect_valid = 1; redirect_pc = 32'h40;
    cycle();
    redirect_valid = 0;
    chk("recover_fault", {31'b0, fault}, 32'd0);
    cycle();
    chk("recover_pc", out_pc, 32'h40);

    // Debug held 10 cycles against a wanting fetch
    dbg_req = 1; dbg_addr = 32'h20; gnts = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      gnts += int'(dbg_gnt);
    end
    dbg_req = 0;
    chk("dbg_gnt_count", gnts, 32'd8);
    chk("dbg_rdata_lit", dbg_rdata, 32'hA5A5_0020);
    repeat (3) cycle();

    // Fault with queue occupied, then async reset
    out_ready = 0;
    redirect_valid = 1; redirect_pc = 32'h3F8;
    cycle();
    redirect_valid = 0;
    cycle(); cycle();
    out_ready = 1; cycle();
    out_ready = 0; cycle();
    chk("pre_rst_fault", {31'b0, fault}, 32'd1);
    chk("pre_rst_fault_pc", fault_pc, 32'h400);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_fault", {31'b0, fault}, 32'd0);
    chk("arst_fault_pc", fault_pc, 32'h0);
    chk("arst_rdata", dbg_rdata, 32'h0);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1; out_ready = 1;
    cycle();
    chk("restart_pc", out_pc, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      out_ready = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(24) == 0);
      r = $urandom_range(7);
      case (r)
        0:       redirect_pc = 32'h3F0;
        1:       redirect_pc = ($urandom & 32'h3FC) | 32'h2;
        2:       redirect_pc = 32'h400 + ($urandom & 32'hFFC);
        default: redirect_pc = $urandom & 32'h3FC;
      endcase
      if (dbg_req && last_dwin) dbg_req = 0;
      else if (!dbg_req && $urandom_range(5) == 0) begin
        dbg_req = 1; dbg_addr = $urandom;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
